// File: rtl/adder_bist_ctrl.sv
// BIST sequencer for the scan-equipped adder: drives counter or LFSR operand
// patterns, compacts Sum and the scan-out stream into a MISR, checks a golden signature.
module adder_bist_ctrl #(
  parameter int               WIDTH    = 32,
  parameter int               PATTERNS = 1024,
  parameter int               INNER    = 32,
  parameter int               SCAN_LEN = 32,
  parameter logic [WIDTH-1:0] POLY     = 32'h0040_0007,
  parameter logic [WIDTH-1:0] SEED1    = 32'h0000_0001,
  parameter logic [WIDTH-1:0] SEED2    = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] Sum,
  input  logic             So,
  output logic [WIDTH-1:0] operand_1,
  output logic [WIDTH-1:0] operand_2,
  output logic             NbarT,
  output logic             Si,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam int CNT_MAX = (PATTERNS > SCAN_LEN) ? PATTERNS : SCAN_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(INNER + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_APPLY, S_CAPTURE, S_SCAN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, misr_q, misr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    icnt_q, icnt_d;
  logic             mode_q, mode_d, pass_q, pass_d;

  // One Galois shift; shared by both LFSRs and the MISR.
  function automatic logic [WIDTH-1:0] gstep(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      icnt_q  <= '0;
      mode_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      icnt_q  <= icnt_d;
      mode_q  <= mode_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    icnt_d  = icnt_q;
    mode_d  = mode_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = mode;
          pass_d  = 1'b0;
        end
      end
      S_LOAD: begin
        op1_d   = mode_q ? SEED1 : '0;
        op2_d   = mode_q ? SEED2 : '0;
        misr_d  = '0;
        cnt_d   = '0;
        icnt_d  = '0;
        state_d = S_APPLY;
      end
      S_APPLY: state_d = S_CAPTURE;
      S_CAPTURE: begin
        misr_d = gstep(misr_q) ^ Sum;
        if (mode_q) begin
          op1_d = gstep(op1_q);
          op2_d = gstep(op2_q);
        end else begin
          // icnt tracks count mod INNER without a divider
          op1_d = op1_q + WIDTH'(1);
          if (icnt_q == IW'(INNER - 1)) begin
            op2_d  = op2_q + WIDTH'(1);
            icnt_d = '0;
          end else begin
            icnt_d = icnt_q + IW'(1);
          end
        end
        if (cnt_q == CW'(PATTERNS - 1)) begin
          cnt_d   = '0;
          state_d = S_SCAN;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_APPLY;
        end
      end
      S_SCAN: begin
        misr_d = gstep(misr_q) ^ {{(WIDTH-1){1'b0}}, So};
        if (cnt_q == CW'(SCAN_LEN - 1)) begin
          cnt_d   = '0;
          pass_d  = (misr_d == golden);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign operand_1 = op1_q;
  assign operand_2 = op2_q;
  assign NbarT     = (state_q == S_SCAN);
  assign Si        = 1'b0;
  assign busy      = (state_q == S_LOAD) || (state_q == S_APPLY) ||
                     (state_q == S_CAPTURE) || (state_q == S_SCAN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
- Parametrised built-in self-test controller for the scan-equipped adder netlist (operand_1/operand_2/Sum, NbarT/Si/So).
- Generates operand patterns in one of two modes: nested counter or dual-LFSR pseudo-random.
- Applies each pattern in normal mode, compacts every Sum into a MISR, then scans the chain out in test mode, folding So into the MISR.
- Compares the final signature against a golden value. It replaces hand-written stimulus loops with a synthesizable on-chip sequencer.

Parameters:
- WIDTH, 32, operand/Sum/MISR width.
- PATTERNS, 1024, number of patterns applied per run (>=1).
- INNER, 32, counter mode: operand_2 increments once every INNER patterns (>=1).
- SCAN_LEN, 32, scan-unload cycles after the last pattern (>=1).
- POLY, 32'h0040_0007, Galois feedback taps (x^32+x^22+x^2+x+1) for the LFSRs and the MISR.
- SEED1, 32'h0000_0001, LFSR-1 seed (nonzero).
- SEED2, 32'hACE1_0001, LFSR-2 seed (nonzero).

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to begin a run; sampled only in IDLE or DONE.
- mode, in, 1, 0 = counter, 1 = LFSR; sampled with start.
- golden, in, WIDTH, expected signature; sampled at end of run.
- Sum, in, WIDTH, adder result under test.
- So, in, 1, scan-out of adder chain.
- operand_1, out, WIDTH, pattern operand 1.
- operand_2, out, WIDTH, pattern operand 2.
- NbarT, out, 1, 0 = normal, 1 = test/scan.
- Si, out, 1, scan-in to adder chain.
- busy, out, 1, run in progress.
- done, out, 1, high in DONE.
- pass, out, 1, signature == golden; valid while done.
- signature, out, WIDTH, current MISR contents.

Behaviour:
- Reset (async, any state): state=IDLE; operand_1=operand_2=0; NbarT=0; Si=0; busy=done=pass=0; MISR=0; pattern counter=0.
- States: IDLE, LOAD, APPLY, CAPTURE, SCAN, DONE.
- IDLE/DONE + start=1 -> LOAD. Latch mode. busy=1, done=0, pass=0.
- LOAD (1 cycle):
  - Counter mode: operand_1=operand_2=0.
  - LFSR mode: operand_1=SEED1, operand_2=SEED2.
  - MISR=0, pattern counter=0. -> APPLY.
- APPLY (1 cycle): NbarT=0, operands held stable. -> CAPTURE.
- CAPTURE (1 cycle):
  - MISR <= (MISR<<1) ^ (MISR[WIDTH-1] ? POLY : 0) ^ Sum.
  - Advance pattern:
    - Counter mode: operand_1+1 mod 2^WIDTH; operand_2+1 when (count mod INNER)==INNER-1.
    - LFSR mode: both LFSRs step one Galois shift with POLY.
  - If count==PATTERNS-1 -> SCAN; else count+1 -> APPLY.
- SCAN (SCAN_LEN cycles):
  - NbarT=1, Si=0.
  - Each cycle: MISR <= (MISR<<1) ^ (MISR[WIDTH-1] ? POLY : 0) ^ {{WIDTH-1{0}},So}.
  - After SCAN_LEN cycles -> DONE.
- DONE: NbarT=0, busy=0, done=1, pass=(MISR==golden) registered on entry. Both are held until the next start or reset.
- Latency start-sample to done=1: 1 + 2*PATTERNS + SCAN_LEN cycles.
- start while busy: ignored; no restart.
- mode changes mid-run: ignored.
- Counter wrap: operands wrap modulo 2^WIDTH silently.
- LFSR never loaded with 0. A zero seed parameter is illegal; the bench asserts on it.
- Reset mid-run: immediate return to reset values. No partial done/pass.
- start in same cycle as the DONE entry: not possible; start is sampled only once already in DONE.
- signature is visible continuously and reflects the MISR, including mid-run.

Test Plan:
1. Reset: assert rst_n=0 mid-SCAN -> all outputs 0 in the same cycle, state IDLE; release -> idle until start.
2. Counter sequence (WIDTH=8, PATTERNS=4, INNER=2, SCAN_LEN=2, Sum model=op1+op2, So=0): operand pairs in successive APPLY cycles = (0,0),(1,0),(2,1),(3,1); done rises exactly 11 cycles after start.
3. Signature pass/fail: run test 2 with golden = bench-computed MISR -> pass=1, done=1 held. Rerun with golden^1 -> pass=0.
4. Fault sensitivity: force Sum bit 0 stuck-at-1 in the model -> final signature differs from fault-free value; pass=0.
5. LFSR mode (WIDTH=8, POLY=8'h1D, SEED1=8'h01): operand_1 sequence 01,02,04,08,10,20,40,80,1D; NbarT=0 during APPLY/CAPTURE; busy high throughout.
6. Scan fold and start handling: So=1 for all SCAN cycles with Sum=0 -> signature equals bench-computed serial-fold value. start pulsed while busy -> run length unchanged. start in DONE -> new run, done drops next cycle.
